// File: rtl/bp_gshare_table_ctrl.sv
// Gshare pattern-history table controller: owns the global history, clears the
// external single-port counter SRAM, and turns queued branch resolutions into counter updates.
//
// state  | meaning
// CLEAR  | sweeping every table entry to weakly not-taken
// IDLE   | serving lookups or issuing the read half of a queued update
// UPD_WR | writing the updated counter back to the head entry's index
module bp_gshare_table_ctrl #(
  parameter int CTableSize = 1024,
  parameter int CounterLen = 2,
  parameter int GHRLen     = 10,
  parameter int QueueDepth = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  output logic                  busy_o,
  input  logic                  lookup_req_i,
  input  logic [31:0]           lookup_pc_i,
  output logic                  lookup_gnt_o,
  output logic                  lookup_rvalid_o,
  output logic                  lookup_taken_o,
  input  logic                  res_valid_i,
  input  logic [31:0]           res_pc_i,
  input  logic                  res_taken_i,
  output logic                  res_ready_o,
  output logic [GHRLen-1:0]     ghr_o,
  output logic                  tbl_req_o,
  output logic                  tbl_we_o,
  output logic [GHRLen-1:0]     tbl_addr_o,
  output logic [CounterLen-1:0] tbl_wdata_o,
  input  logic [CounterLen-1:0] tbl_rdata_i
);

  localparam int PtrW = $clog2(QueueDepth);
  localparam logic [CounterLen-1:0] CtrInit = CounterLen'((2 ** (CounterLen - 1)) - 1);
  localparam logic [CounterLen-1:0] CtrMax  = '1;
  localparam logic [GHRLen-1:0]     ClrLast = GHRLen'(CTableSize - 1);
  localparam logic [PtrW:0]         QFull   = (PtrW + 1)'(QueueDepth);

  typedef enum logic [1:0] {
    ST_CLEAR  = 2'd0,
    ST_IDLE   = 2'd1,
    ST_UPD_WR = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [GHRLen-1:0]     clr_cnt;
  logic [GHRLen-1:0]     ghr;
  logic [GHRLen-1:0]     fifo_idx [QueueDepth];
  logic [QueueDepth-1:0] fifo_taken;
  logic [PtrW-1:0]       wr_ptr, rd_ptr;
  logic [PtrW:0]         count;
  logic                  full, empty, push, pop;
  logic                  upd_start;
  logic                  rvalid;
  logic [GHRLen-1:0]     lookup_idx, res_idx, head_idx;
  logic                  head_taken;
  logic [CounterLen-1:0] ctr_nxt;
  logic                  unused_pc_bits;

  assign unused_pc_bits = ^{lookup_pc_i[31:GHRLen+2], lookup_pc_i[1:0],
                            res_pc_i[31:GHRLen+2], res_pc_i[1:0]};

  assign lookup_idx = lookup_pc_i[GHRLen+1:2] ^ ghr;
  assign res_idx    = res_pc_i[GHRLen+1:2] ^ ghr;
  assign head_idx   = fifo_idx[rd_ptr];
  assign head_taken = fifo_taken[rd_ptr];

  assign full        = (count == QFull);
  assign empty       = (count == '0);
  assign res_ready_o = !full && (state != ST_CLEAR);
  assign push        = res_valid_i && res_ready_o;
  assign pop         = (state == ST_UPD_WR) && !flush_i;
  // Lookups win unless the queue is full, so updates only starve fetch when backed up.
  assign upd_start   = (state == ST_IDLE) && !empty && (full || !lookup_req_i);

  assign ghr_o           = ghr;
  assign lookup_rvalid_o = rvalid;
  assign lookup_taken_o  = rvalid ? tbl_rdata_i[CounterLen-1] : 1'b0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= ST_CLEAR;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_CLEAR:  if (clr_cnt == ClrLast) state_nxt = ST_IDLE;
      ST_IDLE:   if (upd_start) state_nxt = ST_UPD_WR;
      ST_UPD_WR: state_nxt = ST_IDLE;
      default:   state_nxt = ST_CLEAR;
    endcase
    if (flush_i) state_nxt = ST_CLEAR;
  end

  always_comb begin
    busy_o       = 1'b0;
    lookup_gnt_o = 1'b0;
    tbl_req_o    = 1'b0;
    tbl_we_o     = 1'b0;
    tbl_addr_o   = '0;
    tbl_wdata_o  = CtrInit;
    unique case (state)
      ST_CLEAR: begin
        busy_o     = 1'b1;
        tbl_req_o  = 1'b1;
        tbl_we_o   = 1'b1;
        tbl_addr_o = clr_cnt;
      end
      ST_IDLE: begin
        if (upd_start) begin
          tbl_req_o  = 1'b1;
          tbl_addr_o = head_idx;
        end else if (lookup_req_i) begin
          lookup_gnt_o = 1'b1;
          tbl_req_o    = 1'b1;
          tbl_addr_o   = lookup_idx;
        end
      end
      ST_UPD_WR: begin
        tbl_req_o   = !flush_i;
        tbl_we_o    = !flush_i;
        tbl_addr_o  = head_idx;
        tbl_wdata_o = ctr_nxt;
      end
      default: begin
        busy_o = 1'b1;
      end
    endcase
  end

  always_comb begin
    ctr_nxt = tbl_rdata_i;
    if (head_taken) begin
      if (tbl_rdata_i != CtrMax) ctr_nxt = tbl_rdata_i + CounterLen'(1);
    end else begin
      if (tbl_rdata_i != '0) ctr_nxt = tbl_rdata_i - CounterLen'(1);
    end
  end

  // Counter wraps back to 0 on leaving CLEAR, ready for the next flush.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clr_cnt <= '0;
    end else if (flush_i) begin
      clr_cnt <= '0;
    end else if (state == ST_CLEAR) begin
      clr_cnt <= clr_cnt + GHRLen'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ghr <= '0;
    end else if (flush_i) begin
      ghr <= '0;
    end else if (push) begin
      ghr <= {ghr[GHRLen-2:0], res_taken_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid <= 1'b0;
    end else begin
      rvalid <= lookup_gnt_o;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PtrW'(1);
      if (pop)  rd_ptr <= rd_ptr + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (PtrW + 1)'(1);
        2'b01:   count <= count - (PtrW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_idx[wr_ptr]   <= res_idx;
      fifo_taken[wr_ptr] <= res_taken_i;
    end
  end

endmodule

// File: doc/bp_gshare_table_ctrl.md
Name: bp_gshare_table_ctrl

Overview:
- Controller for a gshare pattern-history table held in an external single-port SRAM with 1-cycle read latency.
- Owns the GHR and runs the table clear sequence after reset or flush.
- Buffers EX-stage branch resolutions in a small FIFO and turns each one into a read-modify-write counter update.
- Arbitrates the single SRAM port between fetch-stage prediction lookups and these updates.

Parameters:
- CTableSize, 1024, counter table entries; must equal 2**GHRLen
- CounterLen, 2, saturating counter width (>=2)
- GHRLen, 10, global history length and index width
- QueueDepth, 4, resolution FIFO entries (power of 2, >=2)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  restart table clear; clears GHR and FIFO
- busy_o  out  1  clear sequence in progress
- lookup_req_i  in  1  fetch requests a prediction
- lookup_pc_i  in  32  fetch PC
- lookup_gnt_o  out  1  lookup accepted this cycle (SRAM read issued)
- lookup_rvalid_o  out  1  prediction valid; exactly 1 cycle after gnt
- lookup_taken_o  out  1  predicted taken = MSB of read counter; 0 when rvalid=0
- res_valid_i  in  1  resolved conditional branch from EX
- res_pc_i  in  32  resolved branch PC
- res_taken_i  in  1  resolved outcome
- res_ready_o  out  1  FIFO can accept a resolution
- ghr_o  out  GHRLen  current global history
- tbl_req_o  out  1  SRAM access
- tbl_we_o  out  1  SRAM write enable
- tbl_addr_o  out  GHRLen  SRAM address
- tbl_wdata_o  out  CounterLen  SRAM write data
- tbl_rdata_i  in  CounterLen  SRAM read data, valid the cycle after a read

Behaviour:
- Counters are unsigned. INIT = 2**(CounterLen-1)-1, i.e. weakly not-taken (01 for 2 bits). MAX = 2**CounterLen-1.
- Index formation:
  - Lookup index = lookup_pc_i[GHRLen+1:2] ^ GHR, using the current-cycle GHR.
  - Resolution index = res_pc_i[GHRLen+1:2] ^ GHR, computed at enqueue with the pre-shift GHR. It is stored in the FIFO with the taken bit.
- GHR shifts at enqueue only: GHR <= {GHR[GHRLen-2:0], res_taken_i}.
- FSM states: CLEAR, IDLE, UPD_WR. Reset (async) forces CLEAR with clr_cnt=0, GHR=0, FIFO empty.
- Reset values: busy_o=1, tbl_req_o=1, tbl_we_o=1, tbl_addr_o=0, tbl_wdata_o=INIT, lookup_gnt_o=0, lookup_rvalid_o=0, lookup_taken_o=0, res_ready_o=0, ghr_o=0.
- CLEAR:
  - Each cycle: tbl_req_o=1, tbl_we_o=1, addr=clr_cnt, wdata=INIT; clr_cnt increments.
  - After the write to CTableSize-1, go to IDLE. Clear takes exactly CTableSize cycles after reset release.
  - busy_o=1, lookup_gnt_o=0, res_ready_o=0.
- IDLE, evaluated in priority order:
  1. FIFO non-empty and (FIFO full or !lookup_req_i): issue a read of the head index (req=1, we=0) and go to UPD_WR.
  2. Else if lookup_req_i: lookup_gnt_o=1 and issue a read of the lookup index. The next cycle gives lookup_rvalid_o=1 and lookup_taken_o=tbl_rdata_i[CounterLen-1].
  3. Else: tbl_req_o=0.
- UPD_WR (1 cycle):
  - c=tbl_rdata_i. Next value: taken ? (c==MAX ? c : c+1) : (c==0 ? c : c-1).
  - Write it to the head index (req=1, we=1), pop FIFO, return to IDLE.
  - lookup_gnt_o=0.
  - An update therefore occupies the port for 2 cycles. Updates starve lookups only while the FIFO is full.
- FIFO:
  - res_ready_o = !full && state!=CLEAR.
  - Enqueue on res_valid_i && res_ready_o. Push and pop may occur in the same cycle.
  - Occupancy wraps correctly at QueueDepth.
- Ordering: a lookup may read an entry whose update is still queued and gets the stale value. This is accepted and not a bug.
- flush_i, in any state:
  - Next state is CLEAR with clr_cnt=0; GHR and FIFO are cleared.
  - An in-flight UPD_WR write in the flush cycle is suppressed (we=0).
  - A lookup granted in the cycle before flush still returns its rvalid.
  - flush_i held high keeps restarting at address 0.

Test Plan:
- Reset release, no traffic -> busy_o=1 for exactly 1024 cycles; writes to addr 0..1023 with data 01; then IDLE, busy_o=0, res_ready_o=1.
- After clear, lookup pc=0x100 -> gnt same cycle, addr 0x040; next cycle rvalid=1, taken=0.
- Resolve pc=0x100 taken twice, no lookups -> first index 0x040, GHR 0x001, counter 01->10; second index 0x041, counter 01->10; GHR=0x003.
- Counter preloaded MAX=11, resolve taken -> writes 11; counter 00, resolve not-taken -> writes 00.
- Hold lookup_req_i=1 and push 5 resolutions back-to-back -> res_ready_o drops after 4; with FIFO full an update wins over the lookup; all 5 updates eventually written.
- flush_i asserted in an UPD_WR cycle -> no write that cycle; next cycle CLEAR at addr 0; ghr_o=0; FIFO empty; busy_o=1 for 1024 cycles.
